parallel_goertzel: RTL and testbench

//  Two-bin Goertzel tone detector on one 8-bit ADC sample stream. Both bins run in parallel on each sample.
//  Per-run magnitudes are averaged over NUM_RUNS blocks, then published as G0/G1 with a G_READY strobe.

---
 rtl/parallel_goertzel.sv | 162 ++++++++++++++++
 tb/tb_parallel_goertzel.sv | 139 +++++++++++++
 2 files changed

// File: rtl/parallel_goertzel.sv
// Two-bin Goertzel tone detector: both bins share the sample stream, each bin owns one
// time-multiplexed multiplier, and per-block powers are averaged over NUM_RUNS blocks.
module parallel_goertzel #(
    parameter int                 NUM_RUNS  = 8,
    parameter int                 BLOCK_LEN = 64,
    parameter logic signed [15:0] COEF0     = 16'sd23170,
    parameter logic signed [15:0] COEF1     = 16'sd0,
    parameter int                 MAG_SHIFT = 8
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        adc_ready,
    input  logic        adc_data_rdy,
    input  logic [7:0]  adc_data,
    output logic [15:0] G0,
    output logic [15:0] G1,
    output logic        G_READY
);
    localparam int CNT_W     = $clog2(BLOCK_LEN) + 1;
    localparam int RUN_W     = $clog2(NUM_RUNS) + 1;
    localparam int AVG_SHIFT = $clog2(NUM_RUNS);
    localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(BLOCK_LEN - 1);
    localparam logic [RUN_W-1:0] LAST_RUN    = RUN_W'(NUM_RUNS - 1);

    typedef enum logic [1:0] {IDLE, UPDATE, POWER} state_t;

    state_t             state;
    logic [2:0]         step;
    logic [CNT_W-1:0]   sample_cnt;
    logic [RUN_W-1:0]   run_cnt;
    logic signed [8:0]  x;

    logic signed [15:0] coef     [2];
    logic signed [23:0] s1       [2];
    logic signed [23:0] s2       [2];
    logic signed [47:0] pw       [2];
    logic [19:0]        acc      [2];
    logic signed [39:0] mul_a    [2];
    logic signed [23:0] mul_b    [2];
    logic signed [63:0] mul_p    [2];
    logic signed [47:0] prod_sh  [2];
    logic signed [23:0] s_next   [2];
    logic signed [47:0] pw_sh    [2];
    logic [15:0]        mag      [2];
    logic [19:0]        acc_next [2];
    logic [15:0]        avg      [2];

    assign coef[0] = COEF0;
    assign coef[1] = COEF1;

    // Multiplier operand schedule. POWER steps: 0 s1*s1, 1 s2*s2, 2 coef*s1,
    // 3 (coef*s1)*s2; each product lands in mul_p one clock later.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            mul_a[b] = 40'(coef[b]);
            mul_b[b] = s1[b];
            if (state == POWER) begin
                case (step)
                    3'd0: mul_a[b] = 40'(s1[b]);
                    3'd1: begin
                        mul_a[b] = 40'(s2[b]);
                        mul_b[b] = s2[b];
                    end
                    3'd3: begin
                        mul_a[b] = mul_p[b][39:0];
                        mul_b[b] = s2[b];
                    end
                    default: ;
                endcase
            end
            prod_sh[b]  = 48'(mul_p[b] >>> 14);
            s_next[b]   = 24'(x) + prod_sh[b][23:0] - s2[b];
            pw_sh[b]    = pw[b] >>> MAG_SHIFT;
            if (pw[b][47])
                mag[b] = 16'd0;
            else if (pw_sh[b] > 48'sd65535)
                mag[b] = 16'hFFFF;
            else
                mag[b] = pw_sh[b][15:0];
            acc_next[b] = acc[b] + {4'd0, mag[b]};
            avg[b]      = 16'(acc_next[b] >> AVG_SHIFT);
        end
    end

    // adc_data_rdy is a one-clock valid; the implicit ready is (state == IDLE && adc_ready).
    // A strobe seen while not ready is dropped, never queued.
    always_ff @(posedge sys_clk) begin
        G_READY <= 1'b0;
        if (!rst_n || !adc_ready) begin
            if (!rst_n) begin
                G0 <= 16'd0;
                G1 <= 16'd0;
            end
            state      <= IDLE;
            step       <= 3'd0;
            sample_cnt <= '0;
            run_cnt    <= '0;
            x          <= 9'sd0;
            for (int b = 0; b < 2; b++) begin
                s1[b]    <= 24'sd0;
                s2[b]    <= 24'sd0;
                pw[b]    <= 48'sd0;
                acc[b]   <= 20'd0;
                mul_p[b] <= 64'sd0;
            end
        end else begin
            for (int b = 0; b < 2; b++)
                mul_p[b] <= 64'(mul_a[b]) * 64'(mul_b[b]);
            case (state)
                IDLE: begin
                    if (adc_data_rdy) begin
                        x     <= $signed({1'b0, adc_data}) - 9'sd128;
                        step  <= 3'd0;
                        state <= UPDATE;
                    end
                end
                UPDATE: begin
                    if (step == 3'd0) begin
                        step <= 3'd1;
                    end else begin
                        for (int b = 0; b < 2; b++) begin
                            s2[b] <= s1[b];
                            s1[b] <= s_next[b];
                        end
                        sample_cnt <= sample_cnt + 1'b1;
                        step       <= 3'd0;
                        state      <= (sample_cnt == LAST_SAMPLE) ? POWER : IDLE;
                    end
                end
                POWER: begin
                    step <= step + 3'd1;
                    case (step)
                        3'd1: for (int b = 0; b < 2; b++) pw[b] <= mul_p[b][47:0];
                        3'd2: for (int b = 0; b < 2; b++) pw[b] <= pw[b] + mul_p[b][47:0];
                        3'd4: for (int b = 0; b < 2; b++) pw[b] <= pw[b] - prod_sh[b];
                        3'd5: begin
                            if (run_cnt == LAST_RUN) begin
                                G0      <= avg[0];
                                G1      <= avg[1];
                                G_READY <= 1'b1;
                                run_cnt <= '0;
                                for (int b = 0; b < 2; b++) acc[b] <= 20'd0;
                            end else begin
                                run_cnt <= run_cnt + 1'b1;
                                for (int b = 0; b < 2; b++) acc[b] <= acc_next[b];
                            end
                            for (int b = 0; b < 2; b++) begin
                                s1[b] <= 24'sd0;
                                s2[b] <= 24'sd0;
                            end
                            sample_cnt <= '0;
                            step       <= 3'd0;
                            state      <= IDLE;
                        end
                        default: ;
                    endcase
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_parallel_goertzel.sv
// Bench for parallel_goertzel: directed tone tables, expected publishes queued by the
// driver and checked by an independent monitor on every G_READY pulse.
`timescale 1ns/1ps
module tb_parallel_goertzel;
    localparam int RUN_LEN = 512;

    logic        sys_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        adc_ready = 1'b0;
    logic        adc_data_rdy = 1'b0;
    logic [7:0]  adc_data = 8'd0;
    logic [15:0] G0;
    logic [15:0] G1;
    logic        G_READY;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int strobe_cyc = 0;
    int strobe_cnt = 0;
    int pulse_cnt = 0;
    int drain = 0;

    // Entry: {publish strobe index, g0_lo, g0_hi, g1_lo, g1_hi}
    logic [79:0] exp_q[$];
    logic [79:0] e;

    logic [7:0] sine_tab[8] = '{8'd128, 8'd218, 8'd255, 8'd218, 8'd128, 8'd38, 8'd1, 8'd38};
    logic [7:0] tone_tab[4] = '{8'd128, 8'd255, 8'd128, 8'd1};

    parallel_goertzel dut (
        .sys_clk      (sys_clk),
        .rst_n        (rst_n),
        .adc_ready    (adc_ready),
        .adc_data_rdy (adc_data_rdy),
        .adc_data     (adc_data),
        .G0           (G0),
        .G1           (G1),
        .G_READY      (G_READY)
    );

    // Clock: 42 ns period (about 24 MHz); 48 clocks is about 2000 ns
    always #21 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input int actual, input int lo, input int hi);
        checks++;
        if (actual < lo || actual > hi) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d..%0d", name, actual, lo, hi);
        end
    endtask

    task automatic send(input logic [7:0] d, input int gap);
        adc_data     = d;
        adc_data_rdy = 1'b1;
        strobe_cyc   = cyc;
        strobe_cnt++;
        @(negedge sys_clk);
        adc_data_rdy = 1'b0;
        repeat (gap - 1) @(negedge sys_clk);
    endtask

    task automatic expect_pub(input int g0_lo, input int g0_hi, input int g1_lo, input int g1_hi,
                              input int after);
        exp_q.push_back({16'(strobe_cnt + after), 16'(g0_lo), 16'(g0_hi), 16'(g1_lo), 16'(g1_hi)});
    endtask

    // Monitor: every pulse must match the oldest queued expectation
    always @(negedge sys_clk) begin
        if (G_READY === 1'b1) begin
            pulse_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse actual=pulse required=none (strobe %0d)", strobe_cnt);
            end else begin
                e = exp_q.pop_front();
                check("pub_strobe_index", strobe_cnt, int'(e[79:64]), int'(e[79:64]));
                check("pub_latency", cyc - strobe_cyc - 1, 0, 16);
                check("pub_g0", int'(G0), int'(e[63:48]), int'(e[47:32]));
                check("pub_g1", int'(G1), int'(e[31:16]), int'(e[15:0]));
            end
        end
    end

    initial begin
        // Reset with the block disabled; strobes must be ignored
        repeat (3) @(negedge sys_clk);
        for (int i = 0; i < 3; i++) send(8'hFF, 4);
        check("rst_g0", int'(G0), 0, 0);
        check("rst_g1", int'(G1), 0, 0);
        check("rst_g_ready", int'(G_READY), 0, 0);

        rst_n = 1'b1;
        for (int i = 0; i < 70; i++) send(sine_tab[i % 8], 16);
        check("disabled_g0", int'(G0), 0, 0);
        check("disabled_g1", int'(G1), 0, 0);

        adc_ready = 1'b1;
        @(negedge sys_clk);

        // DC zero
        expect_pub(0, 0, 0, 0, RUN_LEN);
        for (int i = 0; i < RUN_LEN; i++) send(8'h80, 16);

        // Bin-16 tone: s1 ends at -4064, s2 at 0 -> 4064^2 >> 8 = 64516
        expect_pub(0, 200, 64516, 64516, RUN_LEN);
        for (int i = 0; i < RUN_LEN; i++) send(tone_tab[i % 4], 16);

        // 8-sample sine twice back-to-back at 2000 ns spacing; bin-16 resonator returns to zero
        expect_pub(63871, 65161, 0, 0, RUN_LEN);
        expect_pub(63871, 65161, 0, 0, 2 * RUN_LEN);
        for (int i = 0; i < 2 * RUN_LEN; i++) send(sine_tab[i % 8], 48);

        // Partial run, one-clock enable drop, then a fresh full set
        for (int i = 0; i < 40; i++) send(sine_tab[i % 8], 16);
        adc_ready = 1'b0;
        @(negedge sys_clk);
        adc_ready = 1'b1;
        check("held_g0", int'(G0), 63871, 65161);
        check("held_g1", int'(G1), 0, 0);
        check("held_g_ready", int'(G_READY), 0, 0);
        @(negedge sys_clk);
        expect_pub(0, 200, 64516, 64516, RUN_LEN);
        for (int i = 0; i < RUN_LEN; i++) send(tone_tab[i % 4], 16);

        drain = 0;
        while (exp_q.size() != 0 && drain < 200) begin
            @(negedge sys_clk);
            drain++;
        end
        check("pending_expectations", exp_q.size(), 0, 0);
        check("pulse_count", pulse_cnt, 5, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
